// File: rtl/pattern_det_pkg.sv
// Shared constants for the serial pattern detector: FSM state encoding and
// default parameter values.
package pattern_det_pkg;

  localparam int PAT_W_DEF = 3;
  localparam int CNT_W_DEF = 8;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

endpackage

// File: rtl/pattern_match_counter.sv
// Saturating match counter. A clear and a hit in the same cycle clear first
// and then count the hit, which leaves the counter at one.
module pattern_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_hit,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_hit ? CNT_W'(1) : '0;
    end else if (i_hit && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pattern_detector_n.sv
// Serial pattern detector with runtime-loadable pattern, overlap control and a
// saturating match counter. Define PATTERN_DETECTOR_MATCH_REG_EN to register match.
module pattern_detector_n
  import pattern_det_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_DEF,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(3'b101)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic             overlap_en,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  // The oldest history bit is never compared (the incoming bit takes its
  // place in the window), so only the newest PAT_W-1 bits are stored.
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [0:0]        r_state;
  logic [PAT_W-1:0]  r_pat;

  logic [PAT_W-1:0]  w_next_hist;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_hit;

  assign w_next_hist = {r_hist, data_in};
  assign w_fill_inc  = r_fill + FILL_W'(1);
  assign w_hit       = data_valid && !pat_load && (r_state == ST_ARMED) &&
                       (w_next_hist == r_pat);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= ST_FILL;
      r_pat   <= DEFAULT_PAT;
    end else if (pat_load) begin
      r_pat   <= pat_value;
      r_fill  <= '0;
      r_state <= ST_FILL;
    end else if (data_valid) begin
      r_hist <= w_next_hist[PAT_W-2:0];
      if (w_hit && !overlap_en) begin
        r_fill  <= '0;
        r_state <= ST_FILL;
      end else if (r_state == ST_FILL) begin
        r_fill <= w_fill_inc;
        if (w_fill_inc == FILL_MAX) begin
          r_state <= ST_ARMED;
        end
      end
    end
  end

  pattern_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (count_clr),
    .i_hit   (w_hit),
    .o_count (match_count)
  );

`ifdef PATTERN_DETECTOR_MATCH_REG_EN
  logic r_match;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
    end
  end

  assign match = r_match;
`else
  assign match = w_hit;
`endif

endmodule

// File: doc/pattern_detector_n.md
PATTERN_DETECTOR_N -- requirements
Module: pattern_detector_n

Interface
REQ-001 SHALL have parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-003 SHALL have parameter DEFAULT_PAT, default 3'b101 (PAT_W bits): pattern held after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  1  serial data bit.
REQ-007 SHALL have port data_valid  input  1  data_in is consumed this cycle when high.
REQ-008 SHALL have port pat_load  input  1  load pat_value into the pattern register this cycle.
REQ-009 SHALL have port pat_value  input  PAT_W  new pattern; MSB is the oldest bit.
REQ-010 SHALL have port overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port count_clr  input  1  synchronous clear of match_count.
REQ-012 SHALL have port match  output  1  pattern-detected pulse.
REQ-013 SHALL have port match_count  output  CNT_W  saturating count of matches.

Function
REQ-014 SHALL keep a history register hist[PAT_W-1:0]; on a consumed bit, hist <= {hist[PAT_W-2:0], data_in}.
REQ-015 SHALL keep a fill counter, 0..PAT_W-1 and saturating, counting bits consumed since reset, load, or non-overlap match.
REQ-016 SHALL implement a two-state FSM: FILL (fill < PAT_W-1) and ARMED (fill = PAT_W-1).
- FILL -> ARMED when a consumed bit raises fill to PAT_W-1.
- ARMED -> FILL on pat_load, or on a match with overlap_en=0.
REQ-017 SHALL define the raw hit as data_valid & ARMED & ({hist[PAT_W-2:0], data_in} == pat_reg).
REQ-018 SHALL never raise a hit before PAT_W valid bits have been consumed since reset, load, or non-overlap match.
REQ-019 SHALL, on a hit with overlap_en=1, keep the fill counter, so a pattern suffix can start the next match.
REQ-020 SHALL, on a hit with overlap_en=0, clear the fill counter to 0 on the same edge.
REQ-021 SHALL hold hist, fill and the FSM state unchanged while data_valid=0, and SHALL keep the raw hit low during those cycles.
REQ-022 SHALL give pat_load priority over data_valid in the same cycle:
- pat_reg <= pat_value; fill <= 0; FSM -> FILL;
- that cycle's data bit is discarded and no hit is raised.
REQ-023 SHALL increment match_count by 1 per hit and saturate at 2^CNT_W-1.
REQ-024 SHALL set match_count to 1 when count_clr and a hit occur in the same cycle (clear, then count the hit); count_clr alone sets it to 0.

Reset
REQ-025 SHALL, while rstn=0, force: hist=0, fill=0, FSM=FILL, pat_reg=DEFAULT_PAT, match_count=0, match=0 (registered variant).
REQ-026 SHALL, on reset mid-stream, discard all partial history; detection restarts from an empty history.

Configuration
REQ-027 SHALL support macro PATTERN_DETECTOR_MATCH_REG_EN.
- Defined: match is a flop, asserted for exactly one cycle in the cycle after the completing bit; glitch-free output.
- Undefined: match = raw hit, combinational, asserted in the same cycle as the completing bit; zero latency.
REQ-028 SHALL leave match_count timing (updated at the completing edge) identical in both configurations.

Structure
REQ-029 SHALL place in shared package pattern_det_pkg:
- FSM state encoding localparams (ST_FILL, ST_ARMED);
- defaults PAT_W_DEF=3, CNT_W_DEF=8.
REQ-030 SHALL implement the saturating counter with its clear/hit priority as sub-module pattern_match_counter (parameter CNT_W).

Verification
REQ-031 SHALL cover overlap: PAT_W=3, pattern 101, overlap_en=1, bits 1,0,1,0,1 all valid -> hits on bits 3 and 5; match_count=2.
REQ-032 SHALL cover non-overlap: same stream with overlap_en=0 -> hit on bit 3 only; match_count=1.
REQ-033 SHALL cover reload: pat_load with 110 after bits 1,1, then bits 1,1,0 -> no hit before post-load bit 3; hit on bit 3.
REQ-034 SHALL cover valid gaps: bits 1,(gap),0,(gap 2 cycles),1 -> one hit on the final 1; match low during gaps.
REQ-035 SHALL cover counter saturation and clear: CNT_W=2, 5 overlapping hits -> match_count=3; count_clr concurrent with a hit -> 1.
REQ-036 SHALL cover reset mid-stream: bits 1,0, rstn pulse low, then bit 1 -> no hit; pat_reg=101.
REQ-037 SHALL run every scenario with PATTERN_DETECTOR_MATCH_REG_EN both defined (match one cycle late) and undefined (same cycle).
